// File: rtl/jtcps1_stars_rom.sv
// Star-field ROM responder: fetches 32-bit words as two 16-bit SDRAM beats
// and keeps a one-entry cache that drives rom_ok.
module jtcps1_stars_rom #(
    parameter int              AW   = 22,
    parameter logic [AW-1:0]   BASE = '0
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          rom_cs,
    input  logic [12:0]   rom_addr,
    output logic [31:0]   rom_data,
    output logic          rom_ok,
    output logic [AW-1:0] sdram_addr,
    output logic          sdram_req,
    input  logic          sdram_ack,
    input  logic          sdram_dst,
    input  logic [15:0]   sdram_din
);

    typedef enum logic [1:0] {IDLE, REQ, LO, HI} state_t;

    state_t        state, state_nx;
    logic [12:0]   fetch_addr, fetch_nx;
    logic [12:0]   cached_addr, cached_nx;
    logic          valid, valid_nx;
    logic          req_nx;
    logic [AW-1:0] addr_nx;
    logic [31:0]   data_nx;

    assign rom_ok = valid & rom_cs & (cached_addr == rom_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sdram_req   <= 1'b0;
            sdram_addr  <= '0;
            rom_data    <= '0;
            valid       <= 1'b0;
            cached_addr <= '0;
            fetch_addr  <= '0;
        end else begin
            state       <= state_nx;
            sdram_req   <= req_nx;
            sdram_addr  <= addr_nx;
            rom_data    <= data_nx;
            valid       <= valid_nx;
            cached_addr <= cached_nx;
            fetch_addr  <= fetch_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        req_nx    = sdram_req;
        addr_nx   = sdram_addr;
        data_nx   = rom_data;
        valid_nx  = valid;
        cached_nx = cached_addr;
        fetch_nx  = fetch_addr;
        case (state)
            IDLE: begin
                if (rom_cs && !rom_ok) begin
                    fetch_nx = rom_addr;
                    // low beat address; the arbiter supplies the +1 beat itself
                    addr_nx  = BASE + AW'({rom_addr, 1'b0});
                    req_nx   = 1'b1;
                    valid_nx = 1'b0;
                    state_nx = REQ;
                end
            end
            REQ: begin
                if (sdram_ack) begin
                    req_nx   = 1'b0;
                    state_nx = LO;
                end
            end
            LO: begin
                if (sdram_dst) begin
                    data_nx[15:0] = sdram_din;
                    state_nx      = HI;
                end
            end
            HI: begin
                if (sdram_dst) begin
                    data_nx[31:16] = sdram_din;
                    cached_nx      = fetch_addr;
                    valid_nx       = 1'b1;
                    state_nx       = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
